// File: rtl/serial_demux_deser.sv
// Serial-to-parallel receiver: demuxes each qualified serial bit into a word
// register and presents completed words through a one-word valid/ready buffer.
//
// Buffer FSM states:
//   state | meaning
//   EMPTY | no unconsumed word; outValid=0, a completed word loads directly
//   FULL  | outData holds a word; a new word loads only alongside a pop
module serial_demux_deser #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inBit,
  input  logic              inValid,
  input  logic              inSync,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              outOverflow,
  output logic [CW-1:0]     outBitCnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  localparam logic [CW-1:0] LAST_POS = CW'(DATA_W - 1);

  buf_state_t         buf_q, buf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ovf_q, ovf_d;

  logic [CW-1:0]      cnt_eff;
  logic [CW-1:0]      pos;
  logic               word_start;
  logic               done;
  logic [DATA_W-1:0]  word_next;

  // A sync forces the incoming bit to be bit 0 of a fresh word.
  always_comb begin
    cnt_eff    = inSync ? '0 : cnt_q;
    word_start = inSync || (cnt_q == '0);
    pos        = LSB_FIRST ? cnt_eff : (LAST_POS - cnt_eff);
    word_next  = word_start ? '0 : word_q;
    word_next[pos] = inBit;
    done       = inValid && (cnt_eff == LAST_POS);
  end

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (inValid) begin
      word_d = word_next;
      cnt_d  = done ? '0 : cnt_eff + 1'b1;
    end else if (inSync) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    buf_d  = buf_q;
    data_d = data_q;
    ovf_d  = 1'b0;
    case (buf_q)
      EMPTY: begin
        if (done) begin
          data_d = word_next;
          buf_d  = FULL;
        end
      end
      FULL: begin
        if (done) begin
          // Pop and new word in the same cycle keep the buffer full with no bubble.
          if (outReady) data_d = word_next;
          else          ovf_d  = 1'b1;
        end else if (outReady) begin
          buf_d = EMPTY;
        end
      end
      default: buf_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= EMPTY;
      cnt_q  <= '0;
      word_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign outData     = data_q;
  assign outValid    = (buf_q == FULL);
  assign outOverflow = ovf_q;
  assign outBitCnt   = cnt_q;

endmodule

// File: tb/tb_serial_demux_deser.sv
// Directed bench for serial_demux_deser: LSB-first and MSB-first instances share
// stimulus and are compared every cycle against a bit-list/buffer model.
module tb_serial_demux_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, inBit, inValid, inSync, outReady;
  logic [W-1:0] data_l, data_m;
  logic         vld_l, vld_m, ovf_l, ovf_m;
  logic [2:0]   cnt_l, cnt_m;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_demux_deser #(.DATA_W(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .inBit(inBit), .inValid(inValid), .inSync(inSync),
    .outData(data_l), .outValid(vld_l), .outReady(outReady),
    .outOverflow(ovf_l), .outBitCnt(cnt_l));

  serial_demux_deser #(.DATA_W(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .inBit(inBit), .inValid(inValid), .inSync(inSync),
    .outData(data_m), .outValid(vld_m), .outReady(outReady),
    .outOverflow(ovf_m), .outBitCnt(cnt_m));

  // Model: list of received bits, then a word built in each bit order.
  int       m_cnt = 0;
  bit       m_bits[W];
  bit       m_vld = 1'b0;
  bit       m_ovf = 1'b0;
  bit [W-1:0] m_dl = '0, m_dm = '0;

  always @(posedge clk) begin
    bit complete;
    bit was_vld;
    bit [W-1:0] wl, wm;
    complete = 1'b0;
    was_vld  = m_vld;
    wl = '0;
    wm = '0;
    if (rst) begin
      m_cnt = 0; m_vld = 0; m_ovf = 0; m_dl = '0; m_dm = '0;
      for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (inValid) begin
        if (inSync) m_cnt = 0;
        m_bits[m_cnt] = inBit;
        m_cnt++;
        if (m_cnt == W) begin
          complete = 1'b1;
          m_cnt = 0;
          for (int i = 0; i < W; i++) begin
            wl = wl | (W'(m_bits[i]) << i);
            wm = wm | (W'(m_bits[i]) << (W - 1 - i));
          end
        end
      end else if (inSync) begin
        m_cnt = 0;
      end
      if (complete) begin
        if (!was_vld || outReady) begin
          m_dl = wl; m_dm = wm; m_vld = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (was_vld && outReady) begin
        m_vld = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("lsb_data",  32'(data_l), 32'(m_dl));
      check("lsb_valid", 32'(vld_l),  32'(m_vld));
      check("lsb_ovf",   32'(ovf_l),  32'(m_ovf));
      check("lsb_cnt",   32'(cnt_l),  32'(m_cnt));
      check("msb_data",  32'(data_m), 32'(m_dm));
      check("msb_valid", 32'(vld_m),  32'(m_vld));
      check("msb_ovf",   32'(ovf_m),  32'(m_ovf));
      check("msb_cnt",   32'(cnt_m),  32'(m_cnt));
    end
  end

  task automatic send(input logic b, input logic s, input logic v, input logic r);
    inBit = b; inSync = s; inValid = v; outReady = r;
    @(posedge clk);
    #1;
  endtask

  // Bits are sent in index order: val[0] first.
  task automatic send_word(input logic [W-1:0] val, input logic r, input int gaps);
    for (int i = 0; i < W; i++) begin
      send(val[i], i == 0, 1'b1, r);
      if (gaps != 0 && i != W - 1) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) send(1'b0, 1'b0, 1'b0, r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; inBit = 0; inValid = 0; inSync = 0; outReady = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: reset mid-word
    send(1, 1, 1, 0); send(0, 0, 1, 0); send(1, 0, 1, 0); send(1, 0, 1, 0); send(0, 0, 1, 0);
    check("t1_cnt5", 32'(cnt_l), 32'd5);
    rst = 1'b1;
    send(1, 0, 1, 0); send(1, 0, 1, 0);
    rst = 1'b0;
    check("t1_valid", 32'(vld_l), 32'd0);
    check("t1_data",  32'(data_l), 32'd0);
    check("t1_cnt",   32'(cnt_l), 32'd0);
    check("t1_ovf",   32'(ovf_l), 32'd0);

    // T2/T3: bits 1,0,1,0,0,1,0,1
    send_word(8'hA5, 1'b1, 0);
    check("t2_valid", 32'(vld_l), 32'd1);
    check("t2_lsb",   32'(data_l), 32'hA5);
    check("t3_msb",   32'(data_m), 32'hA5);
    send(0, 0, 0, 1);
    check("t2_pop", 32'(vld_l), 32'd0);
    // bits 1,1,0,0,0,0,0,0
    send_word(8'h03, 1'b1, 0);
    check("t3_lsb", 32'(data_l), 32'h03);
    check("t3_msb2", 32'(data_m), 32'hC0);
    send(0, 0, 0, 1);

    // T4: gaps between bits
    send_word(8'hA5, 1'b1, 1);
    check("t4_lsb", 32'(data_l), 32'hA5);
    send(0, 0, 0, 1);

    // T5: partial word then resync
    send(1, 1, 1, 1); send(1, 0, 1, 1); send(1, 0, 1, 1);
    send_word(8'h3C, 1'b1, 0);
    check("t5_lsb", 32'(data_l), 32'h3C);
    check("t5_msb", 32'(data_m), 32'h3C);
    send(0, 0, 0, 1);
    // sync without valid discards the partial word
    send(1, 1, 1, 1); send(1, 0, 1, 1); send(0, 1, 0, 1);
    check("t5_cnt0", 32'(cnt_l), 32'd0);

    // T6: backpressure and overflow
    send_word(8'h11, 1'b0, 0);
    check("t6_first", 32'(data_l), 32'h11);
    send_word(8'h22, 1'b0, 0);
    check("t6_ovf",  32'(ovf_l), 32'd1);
    check("t6_hold", 32'(data_l), 32'h11);
    check("t6_msbh", 32'(data_m), 32'h88);
    send(0, 0, 0, 0);
    check("t6_ovf_pulse", 32'(ovf_l), 32'd0);
    for (int i = 0; i < W; i++) send(1'(8'h33 >> i), i == 0, 1'b1, i == W - 1);
    check("t6_nobubble", 32'(vld_l), 32'd1);
    check("t6_new",      32'(data_l), 32'h33);
    check("t6_newm",     32'(data_m), 32'hCC);
    send(0, 0, 0, 1);
    check("t6_drain", 32'(vld_l), 32'd0);
    send(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
